// File: rtl/row_shuffler.sv
// Shuffle pool generator: a sequential Fisher-Yates permutation of the w one-hot rows,
// plus a constant all-zero row at index w, driven by a 16-bit Galois LFSR.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module row_shuffler #(
    parameter int          w    = `GRID_LEN,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic [(w+1)*w-1:0] pool,
    output logic               valid
);

    localparam int           R        = (w > 1) ? $clog2(w) : 1;
    localparam logic [15:0]  SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [R-1:0] K_INIT   = R'(w - 1);

    typedef enum logic {
        IDLE,
        SHUFFLE
    } state_e;

    state_e       state_q, state_d;
    logic [R-1:0] k_q, k_d;
    logic [15:0]  lfsr_q, lfsr_d;
    logic [w-1:0] pool_q [w];
    logic [w-1:0] pool_d [w];
    logic [R-1:0] r;

    assign r = lfsr_q[R-1:0];

    // NOTE: every variable gets its default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pool_d  = pool_q;
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        case (state_q)
            SHUFFLE: begin
                // Rejected candidates (r > k) leave pool and k untouched; the LFSR still moves on.
                if (r <= k_q) begin
                    pool_d[k_q] = pool_q[r];
                    pool_d[r]   = pool_q[k_q];
                    k_d         = k_q - R'(1);
                    if (k_q == R'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                // A single row has only one permutation, so there is nothing to reshuffle.
                if (start && (w > 1)) begin
                    k_d     = K_INIT;
                    state_d = SHUFFLE;
                end
            end
        endcase
    end

    // NOTE: the pool rows are reset because the identity permutation is the functional start point.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= (w > 1) ? SHUFFLE : IDLE;
            k_q     <= K_INIT;
            lfsr_q  <= SEED_EFF;
            for (int i = 0; i < w; i++) begin
                pool_q[i] <= w'(1) << i;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            k_q     <= k_d;
            lfsr_q  <= lfsr_d;
            pool_q  <= pool_d;
        end
    end

    always_comb begin
        pool = '0;
        for (int i = 0; i < w; i++) begin
            pool[i*w +: w] = pool_q[i];
        end
    end

    assign valid = (state_q == IDLE);

endmodule

// File: tb/tb_row_shuffler.sv
// Directed bench for row_shuffler: widths 1, 2 and 9, several seeds, reshuffle and mid-shuffle reset.
// Expected permutations for w=9 come from a sequential Fisher-Yates reference written here.
module tb_row_shuffler;

    localparam int W  = 9;
    localparam int PW = (W + 1) * W;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset   = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic start_c = 1'b0;
    logic start_d = 1'b0;
    logic start_e = 1'b0;

    logic [PW-1:0] pool_a, pool_b, pool_e;
    logic [1:0]    pool_c;
    logic [5:0]    pool_d;
    logic          valid_a, valid_b, valid_c, valid_d, valid_e;

    int assertions = 0;
    int failures   = 0;
    int a_edges    = 0;
    int rise_a, rise_b, rise_d, rise_e;
    bit c_dropped;

    logic [W*W-1:0] identity;
    logic [W*W-1:0] ref_pool;
    int             ref_rise;

    row_shuffler #(.w(W)) u_a (
        .clock(clock), .reset(reset), .start(start_a), .pool(pool_a), .valid(valid_a)
    );
    row_shuffler #(.w(W), .SEED(16'h1234)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .pool(pool_b), .valid(valid_b)
    );
    row_shuffler #(.w(1)) u_c (
        .clock(clock), .reset(reset), .start(start_c), .pool(pool_c), .valid(valid_c)
    );
    row_shuffler #(.w(2)) u_d (
        .clock(clock), .reset(reset), .start(start_d), .pool(pool_d), .valid(valid_d)
    );
    row_shuffler #(.w(W), .SEED(16'h0000)) u_e (
        .clock(clock), .reset(reset), .start(start_e), .pool(pool_e), .valid(valid_e)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l, input int n);
        logic [15:0] v;
        v = l;
        for (int i = 0; i < n; i++) v = lfsr_next(v);
        return v;
    endfunction

    // Returns the number of cycles the shuffle takes; lin is the LFSR value seen on the first cycle.
    function automatic int model_shuffle(input logic [W*W-1:0] pin, input logic [15:0] lin,
                                         output logic [W*W-1:0] pout);
        logic [W*W-1:0] p;
        logic [15:0]    l;
        logic [W-1:0]   t;
        int             k, r, n;
        p = pin;
        l = lin;
        k = W - 1;
        n = 0;
        while (k >= 1 && n < 10000) begin
            r = int'(l[3:0]);
            if (r <= k) begin
                t              = p[k*W +: W];
                p[k*W +: W]    = p[r*W +: W];
                p[r*W +: W]    = t;
                k--;
            end
            l = lfsr_next(l);
            n++;
        end
        pout = p;
        return n;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        a_edges++;
    endtask

    task automatic clear_rises();
        rise_a    = -1;
        rise_b    = -1;
        rise_d    = -1;
        rise_e    = -1;
        c_dropped = 1'b0;
    endtask

    task automatic run_window(input int n);
        for (int i = 1; i <= n; i++) begin
            step();
            if (rise_a < 0 && valid_a === 1'b1) rise_a = i;
            if (rise_b < 0 && valid_b === 1'b1) rise_b = i;
            if (rise_d < 0 && valid_d === 1'b1) rise_d = i;
            if (rise_e < 0 && valid_e === 1'b1) rise_e = i;
            if (valid_c !== 1'b1) c_dropped = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        assertions++;
        if (pool_a !== {{W{1'b0}}, identity}) begin
            failures++; $display("FAIL reset_pool_a: got %h expected %h", pool_a, {{W{1'b0}}, identity});
        end
        assertions++;
        if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid_a: got %b expected 0", valid_a); end
        assertions++;
        if (valid_b !== 1'b0 || valid_e !== 1'b0) begin
            failures++; $display("FAIL reset_valid_be: got %b%b expected 00", valid_b, valid_e);
        end
        assertions++;
        if (pool_d !== 6'b001001 || valid_d !== 1'b0) begin
            failures++; $display("FAIL reset_w2: got pool %b valid %b expected 001001 / 0", pool_d, valid_d);
        end
        assertions++;
        if (pool_c !== 2'b01 || valid_c !== 1'b1) begin
            failures++; $display("FAIL reset_w1: got pool %b valid %b expected 01 / 1", pool_c, valid_c);
        end
        reset   = 1'b0;
        a_edges = 0;
        clear_rises();
        run_window(150);
    endtask

    task automatic test_identity_completion();
        logic [W*W-1:0] mp;
        logic [W-1:0]   or_all;
        int             n;
        n = model_shuffle(identity, 16'hACE1, mp);
        ref_pool = mp;
        ref_rise = n;
        assertions++;
        if (rise_a < 8 || rise_a > 72) begin
            failures++; $display("FAIL valid_rise_bound: got %0d expected 8..72", rise_a);
        end
        assertions++;
        if (rise_a != n) begin failures++; $display("FAIL valid_rise_cycle: got %0d expected %0d", rise_a, n); end
        assertions++;
        if (pool_a[W*W-1:0] !== mp) begin
            failures++; $display("FAIL shuffle_result: got %h expected %h", pool_a[W*W-1:0], mp);
        end
        assertions++;
        if (pool_a[PW-1:W*W] !== '0) begin
            failures++; $display("FAIL zero_entry: got %h expected 0", pool_a[PW-1:W*W]);
        end
        or_all = '0;
        for (int i = 0; i < W; i++) begin
            or_all |= pool_a[i*W +: W];
            assertions++;
            if ($countones(pool_a[i*W +: W]) != 1) begin
                failures++; $display("FAIL onehot_entry%0d: got %b expected one bit set", i, pool_a[i*W +: W]);
            end
        end
        assertions++;
        if (or_all !== 9'h1FF) begin failures++; $display("FAIL entries_or: got %h expected 1ff", or_all); end
    endtask

    task automatic test_degenerate();
        assertions++;
        if (rise_d != 1) begin failures++; $display("FAIL w2_rise: got %0d expected 1", rise_d); end
        assertions++;
        if (pool_d !== 6'b001001) begin failures++; $display("FAIL w2_pool: got %b expected 001001", pool_d); end
        assertions++;
        if (c_dropped) begin failures++; $display("FAIL w1_valid_held: got a low valid expected always 1"); end
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        assertions++;
        if (valid_c !== 1'b1 || pool_c !== 2'b01) begin
            failures++; $display("FAIL w1_start: got pool %b valid %b expected 01 / 1", pool_c, valid_c);
        end
        step();
        assertions++;
        if (valid_c !== 1'b1 || pool_c !== 2'b01) begin
            failures++; $display("FAIL w1_after_start: got pool %b valid %b expected 01 / 1", pool_c, valid_c);
        end
    endtask

    task automatic test_zero_seed();
        logic [W*W-1:0] mp;
        int             n;
        n = model_shuffle(identity, 16'h0001, mp);
        assertions++;
        if (rise_e != n) begin failures++; $display("FAIL zero_seed_rise: got %0d expected %0d", rise_e, n); end
        assertions++;
        if (pool_e[W*W-1:0] !== mp) begin
            failures++; $display("FAIL zero_seed_pool: got %h expected %h", pool_e[W*W-1:0], mp);
        end
    endtask

    task automatic test_determinism();
        logic [W*W-1:0] mb;
        int             nb;
        reset = 1'b1;
        step();
        reset   = 1'b0;
        a_edges = 0;
        clear_rises();
        run_window(150);
        assertions++;
        if (rise_a != ref_rise) begin failures++; $display("FAIL repeat_rise: got %0d expected %0d", rise_a, ref_rise); end
        assertions++;
        if (pool_a[W*W-1:0] !== ref_pool) begin
            failures++; $display("FAIL repeat_pool: got %h expected %h", pool_a[W*W-1:0], ref_pool);
        end
        nb = model_shuffle(identity, 16'h1234, mb);
        assertions++;
        if (rise_b != nb) begin failures++; $display("FAIL seed1234_rise: got %0d expected %0d", rise_b, nb); end
        assertions++;
        if (pool_b[W*W-1:0] !== mb) begin
            failures++; $display("FAIL seed1234_pool: got %h expected %h", pool_b[W*W-1:0], mb);
        end
        assertions++;
        if (pool_b[W*W-1:0] === ref_pool) begin
            failures++; $display("FAIL seed_differs: got %h expected something other than %h", pool_b[W*W-1:0], ref_pool);
        end
    endtask

    task automatic test_reshuffle();
        logic [W*W-1:0] mp;
        int             n, ms, got;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        ms = a_edges;
        assertions++;
        if (valid_a !== 1'b0) begin failures++; $display("FAIL reshuffle_valid_fall: got %b expected 0", valid_a); end
        n   = model_shuffle(ref_pool, lfsr_adv(16'hACE1, ms), mp);
        got = -1;
        for (int i = 1; i <= 150; i++) begin
            if (i == 2 || i == 4) start_a = 1'b1;
            step();
            start_a = 1'b0;
            if (valid_a === 1'b1) begin
                got = i;
                break;
            end
        end
        assertions++;
        if (got != n) begin failures++; $display("FAIL reshuffle_length: got %0d expected %0d", got, n); end
        assertions++;
        if (pool_a[W*W-1:0] !== mp) begin
            failures++; $display("FAIL reshuffle_pool: got %h expected %h", pool_a[W*W-1:0], mp);
        end
        step();
        assertions++;
        if (pool_a[W*W-1:0] !== mp || valid_a !== 1'b1) begin
            failures++; $display("FAIL idle_stable: got %h / %b expected %h / 1", pool_a[W*W-1:0], valid_a, mp);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        assertions++;
        if (pool_a !== {{W{1'b0}}, identity} || valid_a !== 1'b0) begin
            failures++; $display("FAIL midreset_state: got %h / %b expected %h / 0", pool_a, valid_a, {{W{1'b0}}, identity});
        end
        reset   = 1'b0;
        a_edges = 0;
        clear_rises();
        run_window(150);
        assertions++;
        if (rise_a != ref_rise) begin failures++; $display("FAIL midreset_rise: got %0d expected %0d", rise_a, ref_rise); end
        assertions++;
        if (pool_a[W*W-1:0] !== ref_pool) begin
            failures++; $display("FAIL midreset_pool: got %h expected %h", pool_a[W*W-1:0], ref_pool);
        end
    endtask

    initial begin
        for (int i = 0; i < W; i++) identity[i*W +: W] = W'(1) << i;
        test_reset();
        test_identity_completion();
        test_degenerate();
        test_zero_seed();
        test_determinism();
        test_reshuffle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
